// File: rtl/xoodyak_pkg.sv
// Shared types and constants for the Xoodyak output path: block geometry,
// the buffered-entry record and the core's function codes used as tags.
package xoodyak_pkg;

  localparam int XOOD_TEXT_W = 192;
  localparam int XOOD_WORD_W = 32;
  localparam int XOOD_NW     = XOOD_TEXT_W / XOOD_WORD_W;

  typedef struct packed {
    logic [3:0]   tag;
    logic [191:0] data;
  } xood_outent_t;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    KEY   = 4'd1,
    NONCE = 4'd2,
    ABS   = 4'd3,
    ENC   = 4'd4,
    DEC   = 4'd5,
    SQZ   = 4'd6,
    SKY   = 4'd7,
    RAT   = 4'd8
  } xood_fcode_t;

endpackage

// File: rtl/xoodyak_out_serializer_blk_fifo.sv
// xood_blk_fifo: DEPTH-entry register FIFO of tagged result blocks.
// DEPTH must be a power of two so the pointers wrap naturally.
module xood_blk_fifo
  import xoodyak_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  xood_outent_t           wdata,
  output xood_outent_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  xood_outent_t   mem [DEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/xoodyak_out_serializer.sv
// Buffers xoodyak_build result blocks and streams them as MS-first words.
// Define XOOD_OUT_OVF_STICKY_EN for a sticky ovf flag plus a drop counter ovf_cnt.
module xoodyak_out_serializer
  import xoodyak_pkg::*;
#(
  parameter int TEXT_W = 192,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 4
) (
  input  logic                   eph1,
  input  logic                   reset,
  input  logic [TEXT_W-1:0]      textout,
  input  logic                   textout_valid,
  input  logic [4:0]             opmode,
  output logic [WORD_W-1:0]      out_word,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
`ifdef XOOD_OUT_OVF_STICKY_EN
  output logic [7:0]             ovf_cnt,
`endif
  output logic                   ovf
);

  localparam int NW    = TEXT_W / WORD_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  xood_outent_t                 wr_ent;
  xood_outent_t                 head;
  logic [NW-1:0][WORD_W-1:0]    head_words;
  logic [IDX_W-1:0]             widx;
  logic                         full;
  logic                         xfer;
  logic                         pop;
  logic                         push;
  logic                         drop;
  logic                         unused_opmode_hi;

  assign unused_opmode_hi = opmode[4];
  assign wr_ent = '{tag: opmode[3:0], data: textout};

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign out_valid = (fifo_count != '0);
  assign xfer      = out_valid & out_ready;
  assign pop       = xfer & (widx == LAST_IDX);
  assign push      = textout_valid & (~full | pop);
  assign drop      = textout_valid & ~push;

  xood_blk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (eph1),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_ent),
    .rdata (head),
    .count (fifo_count),
    .full  (full)
  );

  // Packed word view puts word 0 (data MSBs) at the highest index.
  assign head_words = head.data;
  assign out_word   = head_words[LAST_IDX - widx];
  assign out_tag    = head.tag;
  assign out_last   = out_valid & (widx == LAST_IDX);

  always_ff @(posedge eph1) begin
    if (reset) begin
      widx <= '0;
    end else if (pop) begin
      widx <= '0;
    end else if (xfer) begin
      widx <= widx + 1'b1;
    end
  end

`ifdef XOOD_OUT_OVF_STICKY_EN
  always_ff @(posedge eph1) begin
    if (reset) begin
      ovf     <= 1'b0;
      ovf_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_cnt != 8'hff) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end
`else
  always_ff @(posedge eph1) begin
    if (reset) begin
      ovf <= 1'b0;
    end else begin
      ovf <= drop;
    end
  end
`endif

endmodule
